uart_cmd_ctrl: RTL and testbench

- Command sequencer between the UART receive path and an 8-bit register bus.
- Consumes bytes from the receiver (8-bit data plus a 1-cycle valid pulse) and parses them into ping, read and write frames.
- Issues the matching register-bus transaction and queues exactly one response byte to the UART transmitter through a valid/ready handshake.
- Aborts stalled frames using an inter-byte timeout and keeps a saturating error count for bring-up debug.

---
 rtl/uart_cmd_ctrl_if.sv | 24 ++
 rtl/uart_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Register-bus and response-byte signals between uart_cmd_ctrl and its peers.
// tx channel: a byte moves on every rising edge where tx_valid_o && tx_ready_i;
// once tx_valid_o rises, tx_data_o holds until that edge and valid never drops early.
interface uart_cmd_ctrl_if;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i;
    logic       reg_ack_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (
        output reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, tx_data_o, tx_valid_o,
        input  reg_rdata_i, reg_ack_i, tx_ready_i
    );

    modport slave (
        input  reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, tx_data_o, tx_valid_o,
        output reg_rdata_i, reg_ack_i, tx_ready_i
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses ping/read/write frames from UART rx bytes, runs the register-bus access
// and queues one response byte; aborts stalled frames and counts errors.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CLOCKS = 60000,
    parameter logic [7:0]  OP_PING        = 8'h50,
    parameter logic [7:0]  OP_READ        = 8'h52,
    parameter logic [7:0]  OP_WRITE       = 8'h57,
    parameter logic [7:0]  WRITE_ACK      = 8'h4B
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    uart_cmd_ctrl_if.master bus,
    output logic        busy_o,
    output logic [7:0]  err_count_o,
    output logic [2:0]  state_o
);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CLOCKS + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLOCKS);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          txv_q, txv_d;
    logic [7:0]    txd_q, txd_d;
    logic [7:0]    err_q, err_d;
    logic          err_inc;

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        we_d    = we_q;
        re_d    = re_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
        err_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == OP_PING) begin
                        state_d = ST_RESP;
                        txv_d   = 1'b1;
                        txd_d   = OP_PING;
                    end else if (rx_data_i == OP_READ || rx_data_i == OP_WRITE) begin
                        state_d = ST_ADDR;
                        is_wr_d = (rx_data_i == OP_WRITE);
                        tmo_d   = TMO_LOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                // A byte in the cycle the counter expires still wins over the timeout.
                if (rx_valid_i) begin
                    addr_d = rx_data_i;
                    tmo_d  = TMO_LOAD;
                    if (is_wr_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_READ;
                        re_d    = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q - TMO_ONE;
                    if (tmo_q <= TMO_ONE) begin
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                        err_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    wdata_d = rx_data_i;
                    tmo_d   = TMO_LOAD;
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_ONE;
                    if (tmo_q <= TMO_ONE) begin
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                        err_inc = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                err_inc = rx_valid_i;
                if (bus.reg_ack_i) begin
                    we_d    = 1'b0;
                    state_d = ST_RESP;
                    txv_d   = 1'b1;
                    txd_d   = WRITE_ACK;
                end
            end
            ST_READ: begin
                err_inc = rx_valid_i;
                if (bus.reg_ack_i) begin
                    re_d    = 1'b0;
                    state_d = ST_RESP;
                    txv_d   = 1'b1;
                    txd_d   = bus.reg_rdata_i;
                end
            end
            ST_RESP: begin
                err_inc = rx_valid_i;
                if (bus.tx_ready_i) begin
                    txv_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                re_d    = 1'b0;
                txv_d   = 1'b0;
            end
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            re_q    <= re_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    assign bus.reg_addr_o  = addr_q;
    assign bus.reg_wdata_o = wdata_q;
    assign bus.reg_we_o    = we_q;
    assign bus.reg_re_o    = re_q;
    assign bus.tx_data_o   = txd_q;
    assign bus.tx_valid_o  = txv_q;
    assign busy_o          = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_RESP);
    assign err_count_o     = err_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frame/timeout/reset scenarios, then random
// frames scored against a frame-level model (register map, response queue, error count).
module tb_uart_cmd_ctrl;
  localparam int unsigned TMO = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clock;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  uart_cmd_ctrl_if bus ();

  logic       auto_mode;
  logic       m_ack, a_ack, m_ready, a_ready;
  logic [7:0] m_rdata, a_rdata;

  assign bus.reg_ack_i   = auto_mode ? a_ack : m_ack;
  assign bus.reg_rdata_i = auto_mode ? a_rdata : m_rdata;
  assign bus.tx_ready_i  = auto_mode ? a_ready : m_ready;

  uart_cmd_ctrl #(.TIMEOUT_CLOCKS(TMO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .bus        (bus),
    .busy_o     (busy),
    .err_count_o(err_count),
    .state_o    (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_vec  = 0;
  int          n_miss = 0;
  int          err_exp = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  mdl_mem [256];
  logic [7:0]  slv_mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic bump_err();
    if (err_exp < 255) err_exp++;
  endtask

  // drivers (called at a falling edge, return at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
    check("wait_idle", busy, 0);
  endtask

  task automatic man_accept_tx();
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    check("tx_valid_drop", bus.tx_valid_o, 0);
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    b = 8'(($urandom_range(0, 255)));
    if (b == 8'h50 || b == 8'h52 || b == 8'h57) b = 8'hFF;
    return b;
  endfunction

  // auto transmitter sink: random ready, pops the expected response queue
  always @(negedge clock) begin
    logic [7:0] e;
    if (auto_mode) begin
      a_ready = ($urandom_range(0, 2) != 0);
      if (a_ready && bus.tx_valid_o) begin
        check("tx_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", bus.tx_data_o, e);
        end
      end
    end
  end

  // auto register slave: random wait states, stray acks while idle
  int wcnt = 0;
  always @(negedge clock) begin
    logic [15:0] w;
    if (auto_mode) begin
      a_ack = 1'b0;
      if (bus.reg_we_o || bus.reg_re_o) begin
        check("we_re_excl", bus.reg_we_o && bus.reg_re_o, 0);
        if (wcnt == 0) begin
          a_ack = 1'b1;
          wcnt  = $urandom_range(0, 4);
          if (bus.reg_we_o) begin
            slv_mem[bus.reg_addr_o] = bus.reg_wdata_o;
            check("wr_expected", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
              w = exp_wr_q.pop_front();
              check("wr_addr_data", {bus.reg_addr_o, bus.reg_wdata_o}, w);
            end
          end else begin
            a_rdata = slv_mem[bus.reg_addr_o];
          end
        end else begin
          wcnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        a_ack   = 1'b1;
        a_rdata = 8'($urandom_range(0, 255));
      end
    end
  end

  initial begin
    logic [7:0] a, d;
    auto_mode = 1'b0;
    m_ack = 1'b0; m_ready = 1'b0; m_rdata = 8'h00;
    a_ack = 1'b0; a_ready = 1'b0; a_rdata = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = 8'h00;
      slv_mem[i] = 8'h00;
    end
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    @(negedge clock);

    check("rst_tx_valid", bus.tx_valid_o, 0);
    check("rst_we", bus.reg_we_o, 0);
    check("rst_re", bus.reg_re_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_addr", bus.reg_addr_o, 0);

    // ping with back-pressure
    send_byte(8'h50);
    check("ping_valid", bus.tx_valid_o, 1);
    check("ping_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("ping_hold_valid", bus.tx_valid_o, 1);
      check("ping_hold_data", bus.tx_data_o, 8'h50);
    end
    man_accept_tx();
    check("ping_idle", busy, 0);
    check("ping_err", err_count, 0);

    // write with 3 wait cycles
    send_byte(8'h57); send_byte(8'h12); send_byte(8'hA5);
    check("wr_we", bus.reg_we_o, 1);
    check("wr_re", bus.reg_re_o, 0);
    check("wr_addr", bus.reg_addr_o, 8'h12);
    check("wr_wdata", bus.reg_wdata_o, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("wr_hold_we", bus.reg_we_o, 1);
      check("wr_no_tx", bus.tx_valid_o, 0);
    end
    m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0;
    check("wr_we_drop", bus.reg_we_o, 0);
    check("wr_tx_valid", bus.tx_valid_o, 1);
    check("wr_tx_data", bus.tx_data_o, 8'h4B);
    man_accept_tx();

    // stray ack with nothing outstanding
    m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_tx", bus.tx_valid_o, 0);
    check("stray_ack_state", state_dbg, ST_IDLE);

    // read
    send_byte(8'h52); send_byte(8'h3C);
    check("rd_re", bus.reg_re_o, 1);
    check("rd_we", bus.reg_we_o, 0);
    check("rd_addr", bus.reg_addr_o, 8'h3C);
    idle(2);
    check("rd_hold_re", bus.reg_re_o, 1);
    m_rdata = 8'hC7; m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0; m_rdata = 8'h00;
    check("rd_re_drop", bus.reg_re_o, 0);
    check("rd_tx_valid", bus.tx_valid_o, 1);
    check("rd_tx_data", bus.tx_data_o, 8'hC7);
    man_accept_tx();

    // inter-byte timeout
    send_byte(8'h57); send_byte(8'h12);
    idle(TMO - 1);
    check("tmo_not_yet", err_count, 0);
    @(negedge clock);
    check("tmo_err", err_count, 1);
    check("tmo_state", state_dbg, ST_IDLE);
    send_byte(8'h50);
    check("tmo_ping_valid", bus.tx_valid_o, 1);
    check("tmo_ping_data", bus.tx_data_o, 8'h50);
    man_accept_tx();

    // byte arriving on the last allowed cycle is accepted
    send_byte(8'h57);
    idle(TMO - 1);
    send_byte(8'h21);
    idle(TMO - 1);
    send_byte(8'h99);
    check("tmo_edge_we", bus.reg_we_o, 1);
    check("tmo_edge_addr", bus.reg_addr_o, 8'h21);
    check("tmo_edge_wdata", bus.reg_wdata_o, 8'h99);
    check("tmo_edge_err", err_count, 1);
    m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0;
    check("tmo_edge_tx", bus.tx_data_o, 8'h4B);
    man_accept_tx();

    // bad opcode and overrun during a write wait
    send_byte(8'hFF);
    check("bad_op_err", err_count, 2);
    send_byte(8'h57); send_byte(8'h20); send_byte(8'h33);
    send_byte(8'h44);
    check("ovr_err", err_count, 3);
    check("ovr_we", bus.reg_we_o, 1);
    check("ovr_addr", bus.reg_addr_o, 8'h20);
    check("ovr_wdata", bus.reg_wdata_o, 8'h33);
    m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0;
    check("ovr_tx", bus.tx_data_o, 8'h4B);
    man_accept_tx();

    // saturation
    for (int i = 0; i < 300; i++) send_byte(bad_byte());
    check("err_saturate", err_count, 255);

    // reset in the middle of a read
    send_byte(8'h52); send_byte(8'h3C);
    check("mid_rst_re_before", bus.reg_re_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_re", bus.reg_re_o, 0);
    check("mid_rst_tx", bus.tx_valid_o, 0);
    check("mid_rst_err", err_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    check("post_rst_state", state_dbg, ST_IDLE);
    check("post_rst_busy", busy, 0);
    check("post_rst_tx", bus.tx_valid_o, 0);

    // random frames against the frame-level model
    err_exp   = 0;
    auto_mode = 1'b1;
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          exp_q.push_back(8'h50);
          send_byte(8'h50);
          wait_idle();
        end
        1: begin
          a = 8'($urandom_range(0, 15));
          d = 8'($urandom_range(0, 255));
          mdl_mem[a] = d;
          exp_wr_q.push_back({a, d});
          exp_q.push_back(8'h4B);
          send_byte(8'h57);
          idle(($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(0, TMO - 1));
          send_byte(a);
          idle($urandom_range(0, TMO - 1));
          send_byte(d);
          wait_idle();
        end
        2: begin
          a = 8'($urandom_range(0, 15));
          exp_q.push_back(mdl_mem[a]);
          send_byte(8'h52);
          idle(($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(0, TMO - 1));
          send_byte(a);
          wait_idle();
        end
        3: begin
          send_byte(bad_byte());
          bump_err();
        end
        4: begin
          if ($urandom_range(0, 1) == 0) begin
            send_byte(8'h52);
          end else begin
            send_byte(8'h57);
            if ($urandom_range(0, 1) == 0) send_byte(8'($urandom_range(0, 255)));
          end
          idle(TMO);
          bump_err();
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            exp_q.push_back(8'h50);
            send_byte(8'h50);
          end else begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            mdl_mem[a] = d;
            exp_wr_q.push_back({a, d});
            exp_q.push_back(8'h4B);
            send_byte(8'h57); send_byte(a); send_byte(d);
          end
          send_byte(8'($urandom_range(0, 255)));
          bump_err();
          wait_idle();
        end
      endcase
      check("rand_err_count", err_count, err_exp);
      idle($urandom_range(0, 2));
    end
    idle(4);
    check("rand_tx_drained", exp_q.size(), 0);
    check("rand_wr_drained", exp_wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
